// File: rtl/apb_req_queue_if.sv
`timescale 1ns/1ps
// Signal bundle between a command source, apb_req_queue, the APB master request
// port and the response consumer.
interface apb_req_queue_if #(
   parameter int ADD_WIDTH = 9,
   parameter int WIDTH     = 32
);
   // Every valid/ready pair transfers on a rising edge where both are high; the
   // payload must stay stable while valid is high and ready is low.
   logic                   cmd_valid;
   logic                   cmd_ready;
   logic                   cmd_write;
   logic [WIDTH/8-1:0]     cmd_strb;
   logic [ADD_WIDTH-1:0]   cmd_addr;
   logic [WIDTH-1:0]       cmd_wdata;
   logic                   transfer;
   logic                   Req_read_write;
   logic [WIDTH/8-1:0]     Req_pstrb;
   logic [ADD_WIDTH-1:0]   Req_addr;
   logic [WIDTH-1:0]       Req_wdata;
   logic [WIDTH-1:0]       Req_rdata;
   logic                   xfer_done;
   logic                   xfer_err;
   logic                   rsp_valid;
   logic                   rsp_ready;
   logic                   rsp_write;
   logic [WIDTH-1:0]       rsp_rdata;
   logic                   rsp_err;

   modport slave (
      input  cmd_valid, cmd_write, cmd_strb, cmd_addr, cmd_wdata,
      input  Req_rdata, xfer_done, xfer_err, rsp_ready,
      output cmd_ready, transfer, Req_read_write, Req_pstrb, Req_addr, Req_wdata,
      output rsp_valid, rsp_write, rsp_rdata, rsp_err
   );

   modport master (
      output cmd_valid, cmd_write, cmd_strb, cmd_addr, cmd_wdata,
      output Req_rdata, xfer_done, xfer_err, rsp_ready,
      input  cmd_ready, transfer, Req_read_write, Req_pstrb, Req_addr, Req_wdata,
      input  rsp_valid, rsp_write, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/apb_req_queue.sv
`timescale 1ns/1ps
// Command FIFO feeding the APB master request port, with a one-deep response
// register capturing read data / slave error of each completed transfer.
module apb_req_queue #(
   parameter int ADD_WIDTH = 9,
   parameter int WIDTH     = 32,
   parameter int DEPTH     = 4
) (
   input  logic           pclk,
   input  logic           presetn,
   apb_req_queue_if.slave bus,
   output logic [0:0]     o_dbg_state
);
   localparam int PW = $clog2(DEPTH);
   localparam int SW = WIDTH / 8;
   localparam logic [PW:0] C_FULL = (PW+1)'(DEPTH);
   localparam logic [PW:0] C_ONE  = (PW+1)'(1);

   typedef struct packed {
      logic                 write;
      logic [SW-1:0]        strb;
      logic [ADD_WIDTH-1:0] addr;
      logic [WIDTH-1:0]     wdata;
   } cmd_t;

   typedef enum logic [0:0] {S_IDLE = 1'b0, S_ISSUE = 1'b1} state_t;

   cmd_t             r_mem [DEPTH];
   logic [PW:0]      r_wr_ptr;
   logic [PW:0]      r_rd_ptr;
   logic             r_cmd_ready;
   state_t           r_state;
   logic             r_transfer;
   cmd_t             r_req;
   logic             r_rsp_valid;
   logic             r_rsp_write;
   logic             r_rsp_err;
   logic [WIDTH-1:0] r_rsp_rdata;

   logic [PW:0]      w_count;
   logic [PW:0]      w_count_nxt;
   logic [PW:0]      w_rd_ptr_p1;
   logic             w_push;
   logic             w_pop;
   logic             w_more;
   logic             w_slot_free;
   cmd_t             w_cmd_in;
   cmd_t             w_head;
   cmd_t             w_next;

   // Read strobes are cleared on entry so the head never carries stale lanes.
   always_comb begin
      w_cmd_in.write = bus.cmd_write;
      w_cmd_in.strb  = bus.cmd_write ? bus.cmd_strb : '0;
      w_cmd_in.addr  = bus.cmd_addr;
      w_cmd_in.wdata = bus.cmd_wdata;
   end

   assign w_count     = r_wr_ptr - r_rd_ptr;
   assign w_push      = bus.cmd_valid & r_cmd_ready;
   assign w_pop       = (r_state == S_ISSUE) & bus.xfer_done;
   assign w_count_nxt = w_count + (PW+1)'(w_push) - (PW+1)'(w_pop);
   assign w_rd_ptr_p1 = r_rd_ptr + C_ONE;
   assign w_head      = r_mem[r_rd_ptr[PW-1:0]];
   // With a single entry left, a same-edge push becomes the next head directly.
   assign w_next      = (w_count == C_ONE) ? w_cmd_in : r_mem[w_rd_ptr_p1[PW-1:0]];
   assign w_more      = (w_count > C_ONE) | w_push;
   assign w_slot_free = ~r_rsp_valid | bus.rsp_ready;

   always_ff @(posedge pclk) begin
      if (w_push) r_mem[r_wr_ptr[PW-1:0]] <= w_cmd_in;
   end

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_cmd_ready <= 1'b0;
         r_state     <= S_IDLE;
         r_transfer  <= 1'b0;
         r_req       <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_write <= 1'b0;
         r_rsp_err   <= 1'b0;
         r_rsp_rdata <= '0;
      end else begin
         r_cmd_ready <= (w_count_nxt != C_FULL);
         if (w_push) r_wr_ptr <= r_wr_ptr + C_ONE;
         if (w_pop)  r_rd_ptr <= w_rd_ptr_p1;

         if (w_pop) begin
            r_rsp_valid <= 1'b1;
            r_rsp_write <= r_req.write;
            r_rsp_err   <= bus.xfer_err;
            r_rsp_rdata <= r_req.write ? '0 : bus.Req_rdata;
         end else if (r_rsp_valid && bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
         end

         case (r_state)
            S_IDLE: begin
               if ((w_count != '0) && w_slot_free) begin
                  r_state    <= S_ISSUE;
                  r_transfer <= 1'b1;
                  r_req      <= w_head;
               end
            end
            S_ISSUE: begin
               // Stay busy only if the consumer is ready to take the response loaded now.
               if (bus.xfer_done) begin
                  if (w_more && bus.rsp_ready) begin
                     r_req <= w_next;
                  end else begin
                     r_state    <= S_IDLE;
                     r_transfer <= 1'b0;
                  end
               end
            end
            default: begin
               r_state    <= S_IDLE;
               r_transfer <= 1'b0;
            end
         endcase
      end
   end

   assign bus.cmd_ready      = r_cmd_ready;
   assign bus.transfer       = r_transfer;
   assign bus.Req_read_write = r_req.write;
   assign bus.Req_pstrb      = r_req.strb;
   assign bus.Req_addr       = r_req.addr;
   assign bus.Req_wdata      = r_req.wdata;
   assign bus.rsp_valid      = r_rsp_valid;
   assign bus.rsp_write      = r_rsp_write;
   assign bus.rsp_err        = r_rsp_err;
   assign bus.rsp_rdata      = r_rsp_rdata;
   assign o_dbg_state        = r_state;
endmodule

// File: tb/tb_apb_req_queue.sv
`timescale 1ns/1ps
// Bench for apb_req_queue: vector table, directed multi-cycle sequences and a
// randomized run against a queue-based transaction model.
module tb_apb_req_queue;
  localparam int AW = 9;
  localparam int W  = 32;
  localparam int D  = 4;
  localparam int SW = W / 8;

  logic       pclk    = 1'b0;
  logic       presetn = 1'b0;
  logic [0:0] dbg_state;

  apb_req_queue_if #(.ADD_WIDTH(AW), .WIDTH(W)) bus();

  apb_req_queue #(.ADD_WIDTH(AW), .WIDTH(W), .DEPTH(D)) dut (
    .pclk        (pclk),
    .presetn     (presetn),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  always #5 pclk = ~pclk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic          write;
    logic [SW-1:0] strb;
    logic [AW-1:0] addr;
    logic [W-1:0]  wdata;
  } cmd_t;

  cmd_t         model_q[$];
  logic [W+1:0] exp_q[$];

  typedef struct {
    logic          cv;
    logic          cw;
    logic [AW-1:0] ca;
    logic [W-1:0]  cd;
    logic [SW-1:0] cs;
    logic          done;
    logic          err;
    logic [W-1:0]  rdata;
    logic          rrdy;
    logic          e_cready;
    logic          e_xfer;
    logic          e_rw;
    logic [AW-1:0] e_addr;
    logic [SW-1:0] e_strb;
    logic [W-1:0]  e_wdata;
    logic          e_rvalid;
    logic          e_rwrite;
    logic [W-1:0]  e_rdata;
    logic          e_rerr;
  } vec_t;

  vec_t vt [10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge pclk);
    #1;
  endtask

  task automatic idle_inputs;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_strb  = '0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.Req_rdata = '0;
    bus.xfer_done = 1'b0;
    bus.xfer_err  = 1'b0;
  endtask

  task automatic set_cmd(input logic wr, input logic [AW-1:0] a, input logic [W-1:0] d,
                         input logic [SW-1:0] s);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
    bus.cmd_strb  = s;
  endtask

  // One randomized cycle: check outputs against the model, drive, then apply the
  // transactions that the coming edge performs to the model.
  task automatic rnd_cycle(input bit allow_push);
    cmd_t         c;
    int           cnt;
    logic [W-1:0] rd;
    logic         er;
    check("rnd cmd_ready", bus.cmd_ready, model_q.size() < D);
    check("rnd rsp_valid", bus.rsp_valid, exp_q.size() != 0);
    check("rnd transfer while empty", bus.transfer & (model_q.size() == 0), 0);
    if (bus.transfer && model_q.size() != 0) begin
      check("rnd Req_read_write", bus.Req_read_write, model_q[0].write);
      check("rnd Req_addr", bus.Req_addr, model_q[0].addr);
      check("rnd Req_pstrb", bus.Req_pstrb, model_q[0].strb);
      check("rnd Req_wdata", bus.Req_wdata, model_q[0].wdata);
    end
    bus.cmd_valid = allow_push && ($urandom_range(0, 2) != 0);
    bus.cmd_write = 1'($urandom_range(0, 1));
    bus.cmd_addr  = AW'($urandom);
    bus.cmd_wdata = $urandom;
    bus.cmd_strb  = SW'($urandom);
    rd = $urandom;
    er = ($urandom_range(0, 4) == 0);
    bus.Req_rdata = rd;
    bus.xfer_err  = er;
    bus.xfer_done = bus.transfer ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
    if (!allow_push) bus.rsp_ready = 1'b1;
    else if (!bus.transfer) bus.rsp_ready = ($urandom_range(0, 3) != 0);
    cnt = model_q.size();
    if (bus.rsp_valid && bus.rsp_ready && exp_q.size() != 0)
      check("rnd response", {bus.rsp_err, bus.rsp_write, bus.rsp_rdata}, exp_q.pop_front());
    if (bus.transfer && bus.xfer_done && model_q.size() != 0) begin
      c = model_q.pop_front();
      exp_q.push_back({er, c.write, (c.write ? {W{1'b0}} : rd)});
    end
    if (bus.cmd_valid && cnt < D) begin
      c.write = bus.cmd_write;
      c.strb  = bus.cmd_write ? bus.cmd_strb : '0;
      c.addr  = bus.cmd_addr;
      c.wdata = bus.cmd_wdata;
      model_q.push_back(c);
    end
    tick;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    // single write, ignored stray done, erroring read followed by a bypassed write
    vt[0] = '{1'b1,1'b1,9'h005,32'hA5A5_0001,4'hF, 1'b0,1'b0,32'h0, 1'b1,
              1'b1,1'b0,1'b0,9'h000,4'h0,32'h0, 1'b0,1'b0,32'h0,1'b0};
    vt[1] = '{1'b0,1'b0,9'h000,32'h0,4'h0, 1'b0,1'b0,32'h0, 1'b1,
              1'b1,1'b1,1'b1,9'h005,4'hF,32'hA5A5_0001, 1'b0,1'b0,32'h0,1'b0};
    vt[2] = '{1'b0,1'b0,9'h000,32'h0,4'h0, 1'b1,1'b0,32'hDEAD_BEEF, 1'b1,
              1'b1,1'b0,1'b0,9'h000,4'h0,32'h0, 1'b1,1'b1,32'h0,1'b0};
    vt[3] = '{1'b0,1'b0,9'h000,32'h0,4'h0, 1'b0,1'b0,32'h0, 1'b1,
              1'b1,1'b0,1'b0,9'h000,4'h0,32'h0, 1'b0,1'b0,32'h0,1'b0};
    vt[4] = '{1'b0,1'b0,9'h000,32'h0,4'h0, 1'b1,1'b0,32'h1111_2222, 1'b1,
              1'b1,1'b0,1'b0,9'h000,4'h0,32'h0, 1'b0,1'b0,32'h0,1'b0};
    vt[5] = '{1'b1,1'b0,9'h1FF,32'h0,4'hF, 1'b0,1'b0,32'h0, 1'b1,
              1'b1,1'b0,1'b0,9'h000,4'h0,32'h0, 1'b0,1'b0,32'h0,1'b0};
    vt[6] = '{1'b0,1'b0,9'h000,32'h0,4'h0, 1'b0,1'b0,32'h0, 1'b1,
              1'b1,1'b1,1'b0,9'h1FF,4'h0,32'h0, 1'b0,1'b0,32'h0,1'b0};
    vt[7] = '{1'b1,1'b1,9'h0AA,32'h1234_5678,4'h3, 1'b1,1'b1,32'hCAFE_0000, 1'b1,
              1'b1,1'b1,1'b1,9'h0AA,4'h3,32'h1234_5678, 1'b1,1'b0,32'hCAFE_0000,1'b1};
    vt[8] = '{1'b0,1'b0,9'h000,32'h0,4'h0, 1'b1,1'b0,32'h5555_5555, 1'b1,
              1'b1,1'b0,1'b0,9'h000,4'h0,32'h0, 1'b1,1'b1,32'h0,1'b0};
    vt[9] = '{1'b0,1'b0,9'h000,32'h0,4'h0, 1'b0,1'b0,32'h0, 1'b1,
              1'b1,1'b0,1'b0,9'h000,4'h0,32'h0, 1'b0,1'b0,32'h0,1'b0};

    // clock / reset
    idle_inputs();
    bus.rsp_ready = 1'b1;
    presetn = 1'b0;
    repeat (3) @(posedge pclk);
    #1;
    check("reset cmd_ready", bus.cmd_ready, 0);
    check("reset transfer", bus.transfer, 0);
    check("reset rsp_valid", bus.rsp_valid, 0);
    check("reset dbg_state", dbg_state, 0);
    presetn = 1'b1;
    check("release cmd_ready before edge", bus.cmd_ready, 0);
    tick;
    check("release cmd_ready after edge", bus.cmd_ready, 1);

    // vector table
    for (int i = 0; i < 10; i++) begin
      bus.cmd_valid = vt[i].cv;
      bus.cmd_write = vt[i].cw;
      bus.cmd_addr  = vt[i].ca;
      bus.cmd_wdata = vt[i].cd;
      bus.cmd_strb  = vt[i].cs;
      bus.xfer_done = vt[i].done;
      bus.xfer_err  = vt[i].err;
      bus.Req_rdata = vt[i].rdata;
      bus.rsp_ready = vt[i].rrdy;
      tick;
      check($sformatf("vec%0d cmd_ready", i), bus.cmd_ready, vt[i].e_cready);
      check($sformatf("vec%0d transfer", i), bus.transfer, vt[i].e_xfer);
      if (vt[i].e_xfer) begin
        check($sformatf("vec%0d Req_read_write", i), bus.Req_read_write, vt[i].e_rw);
        check($sformatf("vec%0d Req_addr", i), bus.Req_addr, vt[i].e_addr);
        check($sformatf("vec%0d Req_pstrb", i), bus.Req_pstrb, vt[i].e_strb);
        check($sformatf("vec%0d Req_wdata", i), bus.Req_wdata, vt[i].e_wdata);
      end
      check($sformatf("vec%0d rsp_valid", i), bus.rsp_valid, vt[i].e_rvalid);
      if (vt[i].e_rvalid) begin
        check($sformatf("vec%0d rsp_write", i), bus.rsp_write, vt[i].e_rwrite);
        check($sformatf("vec%0d rsp_rdata", i), bus.rsp_rdata, vt[i].e_rdata);
        check($sformatf("vec%0d rsp_err", i), bus.rsp_err, vt[i].e_rerr);
      end
    end
    idle_inputs();

    // fill with a stalled master, then drain in order
    acc = 0;
    for (int k = 0; k < 5; k++) begin
      set_cmd(1'b0, AW'(k), W'(k), 4'hF);
      check($sformatf("fill cmd_ready %0d", k), bus.cmd_ready, k < 4);
      if (bus.cmd_ready) acc++;
      tick;
    end
    check("fill accepted count", acc, 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain%0d transfer", i), bus.transfer, 1);
      check($sformatf("drain%0d Req_addr", i), bus.Req_addr, AW'(i));
      check($sformatf("drain%0d Req_pstrb", i), bus.Req_pstrb, 0);
      if (i == 0) check("full pop cmd_ready before edge", bus.cmd_ready, 0);
      bus.xfer_done = 1'b1;
      bus.Req_rdata = 32'h0BAD_0000 + W'(i);
      tick;
      if (i == 0) begin
        check("full pop cmd_ready after edge", bus.cmd_ready, 1);
        bus.cmd_valid = 1'b0;
      end
    end
    bus.xfer_done = 1'b0;
    check("drain end transfer", bus.transfer, 0);
    check("drain end rsp_rdata", bus.rsp_rdata, 32'h0BAD_0003);
    tick;
    check("drain end rsp_valid", bus.rsp_valid, 0);

    // back-to-back reads across the pointer wrap
    for (int i = 0; i < 4; i++) begin
      set_cmd(1'b0, AW'(9'h100 + i), 32'h0, 4'hF);
      tick;
    end
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("b2b%0d transfer", i), bus.transfer, 1);
      check($sformatf("b2b%0d Req_addr", i), bus.Req_addr, AW'(9'h100 + i));
      bus.xfer_done = 1'b1;
      bus.Req_rdata = W'(32'h10 + i);
      tick;
      check($sformatf("b2b%0d rsp_valid", i), bus.rsp_valid, 1);
      check($sformatf("b2b%0d rsp_rdata", i), bus.rsp_rdata, W'(32'h10 + i));
      check($sformatf("b2b%0d rsp_write", i), bus.rsp_write, 0);
    end
    idle_inputs();
    check("b2b end transfer", bus.transfer, 0);
    tick;
    check("b2b end rsp_valid", bus.rsp_valid, 0);

    // response backpressure
    set_cmd(1'b1, 9'h020, 32'hAAAA_0020, 4'hF);
    tick;
    set_cmd(1'b1, 9'h021, 32'hBBBB_0021, 4'hC);
    tick;
    idle_inputs();
    check("bp first Req_addr", bus.Req_addr, 9'h020);
    bus.rsp_ready = 1'b0;
    bus.xfer_done = 1'b1;
    tick;
    bus.xfer_done = 1'b0;
    check("bp transfer dropped", bus.transfer, 0);
    for (int i = 0; i < 3; i++) begin
      tick;
      check($sformatf("bp hold%0d transfer", i), bus.transfer, 0);
      check($sformatf("bp hold%0d rsp_valid", i), bus.rsp_valid, 1);
      check($sformatf("bp hold%0d rsp_write", i), bus.rsp_write, 1);
    end
    bus.rsp_ready = 1'b1;
    tick;
    check("bp resume transfer", bus.transfer, 1);
    check("bp resume Req_addr", bus.Req_addr, 9'h021);
    check("bp resume Req_wdata", bus.Req_wdata, 32'hBBBB_0021);
    check("bp resume Req_pstrb", bus.Req_pstrb, 4'hC);
    check("bp resume rsp_valid", bus.rsp_valid, 0);
    bus.xfer_done = 1'b1;
    tick;
    bus.xfer_done = 1'b0;
    check("bp second rsp_valid", bus.rsp_valid, 1);
    check("bp second transfer", bus.transfer, 0);
    tick;
    check("bp second consumed", bus.rsp_valid, 0);

    // reset in the middle of an issue with a response held
    set_cmd(1'b0, 9'h030, 32'h0, 4'hF);
    tick;
    set_cmd(1'b0, 9'h031, 32'h0, 4'hF);
    tick;
    set_cmd(1'b0, 9'h032, 32'h0, 4'hF);
    tick;
    idle_inputs();
    bus.xfer_done = 1'b1;
    bus.Req_rdata = 32'h7777_7777;
    tick;
    bus.xfer_done = 1'b0;
    check("midrst pre transfer", bus.transfer, 1);
    check("midrst pre rsp_valid", bus.rsp_valid, 1);
    #2;
    presetn = 1'b0;
    #1;
    check("midrst transfer", bus.transfer, 0);
    check("midrst rsp_valid", bus.rsp_valid, 0);
    check("midrst cmd_ready", bus.cmd_ready, 0);
    check("midrst dbg_state", dbg_state, 0);
    @(posedge pclk);
    #1;
    presetn = 1'b1;
    tick;
    check("midrst release cmd_ready", bus.cmd_ready, 1);
    for (int i = 0; i < 3; i++) begin
      tick;
      check($sformatf("midrst idle%0d transfer", i), bus.transfer, 0);
      check($sformatf("midrst idle%0d rsp_valid", i), bus.rsp_valid, 0);
    end

    // randomized run against the model, then drain
    model_q.delete();
    exp_q.delete();
    bus.rsp_ready = 1'b1;
    for (int cyc = 0; cyc < 3000; cyc++) rnd_cycle(1'b1);
    for (int n = 0; n < 300 && (model_q.size() != 0 || exp_q.size() != 0); n++) rnd_cycle(1'b0);
    check("rnd drain complete", (model_q.size() == 0) && (exp_q.size() == 0), 1);
    check("rnd drain transfer", bus.transfer, 0);
    check("rnd drain rsp_valid", bus.rsp_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
